// File: rtl/cpu_sequencer.sv
// Multi-cycle accumulator CPU sequencer: fetch, decode and one memory
// strobe per instruction over a registered 6-bit address / 9-bit data bus.
module cpu_sequencer #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       READ,
  output logic       WRITE,
  output logic [5:0] A,
  output logic [8:0] DATA,
  input  logic [8:0] D,
  output logic [8:0] ACOUT,
  output logic [5:0] PCOUT,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    FETCH_ADDR,
    FETCH_STRB,
    DECODE,
    EXEC_STRB,
    HALT
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b110;
  localparam logic [2:0] OP_STORE = 3'b111;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [5:0]  a_q, a_d;
  logic [5:0]  pc_q, pc_d;
  logic [8:0]  data_q, data_d;
  logic [8:0]  ac_q, ac_d;
  logic [8:0]  ir_q, ir_d;
  logic        halted_q, halted_d;
  logic [2:0]  op;

  assign op = ir_q[8:6];

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    write_d  = write_q;
    a_d      = a_q;
    pc_d     = pc_q;
    data_d   = data_q;
    ac_d     = ac_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    unique case (state_q)
      FETCH_ADDR: begin
        read_d  = 1'b1;
        state_d = FETCH_STRB;
      end
      FETCH_STRB: begin
        read_d  = 1'b0;
        ir_d    = D;
        a_d     = D[5:0];
        data_d  = ac_q;
        pc_d    = pc_q + 6'd1;
        state_d = DECODE;
      end
      DECODE: begin
        unique case (op)
          OP_ADD, OP_AND: begin
            read_d  = 1'b1;
            state_d = EXEC_STRB;
          end
          OP_STORE: begin
            write_d = 1'b1;
            state_d = EXEC_STRB;
          end
          OP_JMP: begin
            pc_d    = ir_q[5:0];
            a_d     = ir_q[5:0];
            state_d = FETCH_ADDR;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
          default: begin
            a_d     = pc_q;
            state_d = FETCH_ADDR;
          end
        endcase
      end
      EXEC_STRB: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        if (op == OP_ADD) begin
          ac_d = ac_q + D;
        end else if (op == OP_AND) begin
          ac_d = ac_q & D;
        end
        a_d     = pc_q;
        state_d = FETCH_ADDR;
      end
      HALT: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = FETCH_ADDR;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= FETCH_ADDR;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      a_q      <= RESET_PC;
      pc_q     <= RESET_PC;
      data_q   <= 9'd0;
      ac_q     <= 9'd0;
      ir_q     <= 9'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      write_q  <= write_d;
      a_q      <= a_d;
      pc_q     <= pc_d;
      data_q   <= data_d;
      ac_q     <= ac_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign READ   = read_q;
  assign WRITE  = write_q;
  assign A      = a_q;
  assign DATA   = data_q;
  assign ACOUT  = ac_q;
  assign PCOUT  = pc_q;
  assign HALTED = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: behavioural memory, bus protocol
// monitor and hand-computed program results.
module tb_cpu_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ, WRITE, HALTED;
  logic [5:0] A, PCOUT;
  logic [8:0] DATA, D, ACOUT;

  logic [8:0] mem [64];
  logic [8:0] img [64];
  event       load_ev;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int st_val [$];
  int st_cyc [$];

  cpu_sequencer #(.RESET_PC(6'd0)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .A(A), .DATA(DATA), .D(D), .ACOUT(ACOUT),
    .PCOUT(PCOUT), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  assign D = mem[A];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  // memory: image load while in reset, otherwise captures on WRITE edge
  always @(posedge WRITE or load_ev) begin
    if (WRITE) begin
      mem[A] = DATA;
      if (A == 6'd11) begin
        st_val.push_back(int'(DATA));
        st_cyc.push_back(cyc);
      end
    end else begin
      mem = img;
      st_val.delete();
      st_cyc.delete();
    end
  end

  always @(posedge READ or posedge WRITE) strobes++;

  logic [5:0] p_a;
  logic [8:0] p_d;
  logic       p_rd, p_wr;

  always @(negedge CLK) begin
    if (RESET) begin
      p_a  = A;
      p_d  = DATA;
      p_rd = 1'b0;
      p_wr = 1'b0;
    end else begin
      chk("rd_wr_excl", READ & WRITE, 0);
      chk("rd_width", p_rd & READ, 0);
      chk("wr_width", p_wr & WRITE, 0);
      if ((READ && !p_rd) || (WRITE && !p_wr))
        chk("a_stable", A, p_a);
      if (WRITE && !p_wr)
        chk("data_stable", DATA, p_d);
      p_a  = A;
      p_d  = DATA;
      p_rd = READ;
      p_wr = WRITE;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 9'd0;
  endtask

  task automatic load_and_start();
    RESET = 1'b1;
    ->load_ev;
    #1;
    @(negedge CLK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    int s0;
    RESET = 1'b1;
    clear_img();
    ->load_ev;
    tick(2);
    chk("rst_read", READ, 0);
    chk("rst_write", WRITE, 0);
    chk("rst_a", A, 0);
    chk("rst_pc", PCOUT, 0);
    chk("rst_ac", ACOUT, 0);
    chk("rst_data", DATA, 0);
    chk("rst_halted", HALTED, 0);

    // HALT at address 0
    clear_img();
    img[0] = 9'h180;
    load_and_start();
    chk("first_read_pre", READ, 0);
    tick(1);
    chk("first_read", READ, 1);
    chk("first_addr", A, 0);
    tick(1);
    chk("halt_early", HALTED, 0);
    tick(1);
    chk("halt_3cyc", HALTED, 1);
    s0 = strobes;
    tick(100);
    chk("halt_strobes", strobes - s0, 0);
    chk("halt_hold", HALTED, 1);
    chk("halt_pc", PCOUT, 1);
    RESET = 1'b1;
    #1;
    chk("halt_release", HALTED, 0);

    // ADD wrap, AND, STORE
    clear_img();
    img[0]  = 9'h014;
    img[1]  = 9'h1DE;
    img[2]  = 9'h015;
    img[3]  = 9'h1DF;
    img[4]  = 9'h017;
    img[5]  = 9'h098;
    img[6]  = 9'h1E0;
    img[7]  = 9'h180;
    img[20] = 9'h1FF;
    img[21] = 9'h001;
    img[23] = 9'h0F3;
    img[24] = 9'h13C;
    load_and_start();
    tick(30);
    chk("arith_not_halted", HALTED, 0);
    tick(1);
    chk("arith_halted", HALTED, 1);
    chk("arith_ac", ACOUT, 9'h030);
    chk("arith_pc", PCOUT, 8);
    chk("store_1ff", mem[30], 9'h1FF);
    chk("add_wrap", mem[31], 0);
    chk("store_and", mem[32], 9'h030);

    // JMP to 63, NOP there wraps PC
    clear_img();
    img[0]  = 9'h13F;
    img[63] = 9'h040;
    load_and_start();
    tick(3);
    chk("jmp_pc", PCOUT, 63);
    chk("jmp_a", A, 63);
    tick(3);
    chk("nop_pc_wrap", PCOUT, 0);
    chk("nop_a", A, 0);

    // Fibonacci loop
    clear_img();
    img[0]  = 9'b010001100;
    img[1]  = 9'b000001010;
    img[2]  = 9'b111001001;
    img[3]  = 9'b010001100;
    img[4]  = 9'b000001011;
    img[5]  = 9'b111001010;
    img[6]  = 9'b000001001;
    img[7]  = 9'b111001011;
    img[8]  = 9'b100000000;
    img[9]  = 9'd0;
    img[10] = 9'd1;
    img[11] = 9'd1;
    img[12] = 9'd0;
    load_and_start();
    for (int i = 0; i < 400 && st_val.size() < 5; i++)
      @(posedge CLK);
    #1;
    chk("fib_count", st_val.size(), 5);
    if (st_val.size() >= 5) begin
      int fib [5];
      fib = '{2, 3, 5, 8, 13};
      for (int i = 0; i < 5; i++)
        chk($sformatf("fib_val%0d", i), st_val[i], fib[i]);
      for (int i = 1; i < 5; i++)
        chk($sformatf("fib_period%0d", i), st_cyc[i] - st_cyc[i-1], 35);
    end

    // reset during ADD read strobe
    clear_img();
    img[0]  = 9'h014;
    img[20] = 9'h005;
    load_and_start();
    tick(3);
    chk("exec_read_hi", READ, 1);
    chk("exec_addr", A, 20);
    RESET = 1'b1;
    #1;
    chk("abort_read", READ, 0);
    chk("abort_ac", ACOUT, 0);
    chk("abort_pc", PCOUT, 0);
    tick(1);
    chk("abort_ac_hold", ACOUT, 0);
    @(negedge CLK);
    #1 RESET = 1'b0;
    tick(4);
    chk("rerun_ac", ACOUT, 5);
    chk("rerun_pc", PCOUT, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
